// File: rtl/gen3_pkt_pkg.sv
// Shared constants and types for the Gen3 packet assembler.
package gen3_pkt_pkg;

    // One-hot byte classification codes from the framing checker.
    localparam logic [5:0] T_DATA      = 6'b100000;
    localparam logic [5:0] T_TLPSTART  = 6'b010000;
    localparam logic [5:0] T_TLPEND    = 6'b001000;
    localparam logic [5:0] T_DLLPEND   = 6'b000100;
    localparam logic [5:0] T_DLLPSTART = 6'b000010;
    localparam logic [5:0] T_TLPEDB    = 6'b000001;

    // Write-side FSM encodings.
    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_TLP     = 2'd1;
    localparam logic [1:0] W_DLLP    = 2'd2;
    localparam logic [1:0] W_DISCARD = 2'd3;

    // Read-side FSM encodings.
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_SEND = 1'b1;

    // Largest packet the descriptor length field can describe.
    localparam int unsigned PKT_MAX_LEN = 32;
    localparam int unsigned LEN_W       = $clog2(PKT_MAX_LEN + 1);

    // Committed-packet descriptor.
    typedef struct packed {
        logic             is_dllp;
        logic [LEN_W-1:0] len;
    } desc_t;

endpackage

// File: rtl/gen3_desc_fifo.sv
// Small synchronous FIFO holding committed-packet descriptors (first-word fall-through).
module gen3_desc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Status flags and next pointers; extra MSB separates full from empty.
    always_comb begin
        empty_c  = (wr_ptr_q == rd_ptr_q);
        full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full_c;
        do_pop   = pop && !empty_c;
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        rd_data_c = mem[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Descriptor storage.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/gen3_packet_assembler.sv
// Buffers framed TLP/DLLP payloads, commits on a good end marker and replays
// committed packets byte-serially. MAX_LEN must not exceed PKT_MAX_LEN.
module gen3_packet_assembler
    import gen3_pkt_pkg::*;
#(
    parameter int unsigned BUF_DEPTH  = 64,
    parameter int unsigned DESC_DEPTH = 4,
    parameter int unsigned MAX_LEN    = PKT_MAX_LEN
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [5:0] in_type,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_is_dllp,
    output logic [7:0] nullify_count,
    output logic [7:0] drop_count
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [7:0]       mem [BUF_DEPTH];

    logic [1:0]       wstate_q, wstate_d;
    logic [PW-1:0]    wr_tmp_q, wr_tmp_d, wr_commit_q, wr_commit_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             push_q, push_d;
    desc_t            push_data_q, push_data_d;
    logic [7:0]       drop_q, drop_d, null_q, null_d;
    logic             mem_we;

    logic [0:0]       rstate_q, rstate_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             kind_q, kind_d, first_q, first_d;
    logic             pop;
    logic             send;

    logic             out_valid_q, out_valid_d, out_sop_q, out_sop_d;
    logic             out_eop_q, out_eop_d, out_is_dllp_q, out_is_dllp_d;
    logic [7:0]       out_data_q, out_data_d;

    desc_t            desc_rd;
    logic             desc_full_c, desc_empty_c;

    logic             is_data, is_start, is_edb, is_tlpend, is_dllpend;
    logic             in_pkt, match_end, buf_full, desc_blocked, drop_inc, null_inc;

    // Input classification; anything that is not an exact one-hot code is ignored.
    always_comb begin
        is_data    = in_valid && (in_type == T_DATA);
        is_start   = in_valid && ((in_type == T_TLPSTART) || (in_type == T_DLLPSTART));
        is_edb     = in_valid && (in_type == T_TLPEDB);
        is_tlpend  = in_valid && (in_type == T_TLPEND);
        is_dllpend = in_valid && (in_type == T_DLLPEND);
    end

    // Write FSM: stage payload at wr_tmp, advance wr_commit only on a good end.
    always_comb begin
        wstate_d     = wstate_q;
        wr_tmp_d     = wr_tmp_q;
        wr_commit_d  = wr_commit_q;
        len_d        = len_q;
        push_d       = 1'b0;
        push_data_d  = push_data_q;
        mem_we       = 1'b0;
        drop_inc     = 1'b0;
        null_inc     = 1'b0;
        in_pkt       = (wstate_q == W_TLP) || (wstate_q == W_DLLP);
        match_end    = ((wstate_q == W_TLP) && is_tlpend) || ((wstate_q == W_DLLP) && is_dllpend);
        buf_full     = ((wr_tmp_q - rd_ptr_q) == PW'(BUF_DEPTH));
        // A descriptor still in flight to the FIFO counts as occupying a slot.
        desc_blocked = desc_full_c || push_q;

        if (is_start) begin
            drop_inc = in_pkt;
            wstate_d = (in_type == T_TLPSTART) ? W_TLP : W_DLLP;
            wr_tmp_d = wr_commit_q;
            len_d    = '0;
        end else if (in_pkt) begin
            if (is_data) begin
                if ((len_q < LEN_W'(MAX_LEN)) && !buf_full) begin
                    mem_we   = 1'b1;
                    wr_tmp_d = wr_tmp_q + PW'(1);
                    len_d    = len_q + LEN_W'(1);
                end else begin
                    drop_inc = 1'b1;
                    wstate_d = W_DISCARD;
                end
            end else if (match_end) begin
                wstate_d = W_IDLE;
                if ((len_q != '0) && !desc_blocked) begin
                    push_d      = 1'b1;
                    push_data_d = '{is_dllp: (wstate_q == W_DLLP), len: len_q};
                    wr_commit_d = wr_tmp_q;
                end else begin
                    drop_inc = 1'b1;
                    wr_tmp_d = wr_commit_q;
                end
            end else if (is_edb || is_tlpend || is_dllpend) begin
                null_inc = is_edb && (wstate_q == W_TLP);
                drop_inc = !(is_edb && (wstate_q == W_TLP));
                wstate_d = W_IDLE;
                wr_tmp_d = wr_commit_q;
            end
        end else if (wstate_q == W_DISCARD) begin
            if (is_edb || is_tlpend || is_dllpend) begin
                wstate_d = W_IDLE;
                wr_tmp_d = wr_commit_q;
            end
        end

        drop_d = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
        null_d = (null_inc && (null_q != 8'hFF)) ? null_q + 8'd1 : null_q;
    end

    // Read FSM and registered output stage.
    always_comb begin
        rstate_d    = rstate_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        kind_d      = kind_q;
        first_d     = first_q;
        pop         = 1'b0;

        if (rstate_q == R_IDLE) begin
            if (!desc_empty_c) begin
                rstate_d    = R_SEND;
                remaining_d = desc_rd.len;
                kind_d      = desc_rd.is_dllp;
                first_d     = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            remaining_d = remaining_q - LEN_W'(1);
            first_d     = 1'b0;
            if (remaining_q == LEN_W'(1)) begin
                pop      = 1'b1;
                rstate_d = R_IDLE;
            end
        end

        send          = (rstate_d == R_SEND);
        out_valid_d   = send;
        out_data_d    = send ? mem[rd_ptr_d[AW-1:0]] : 8'h00;
        out_sop_d     = send && first_d;
        out_eop_d     = send && (remaining_d == LEN_W'(1));
        out_is_dllp_d = send && kind_d;
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wstate_q      <= W_IDLE;
            wr_tmp_q      <= '0;
            wr_commit_q   <= '0;
            len_q         <= '0;
            push_q        <= 1'b0;
            push_data_q   <= '0;
            drop_q        <= '0;
            null_q        <= '0;
            rstate_q      <= R_IDLE;
            rd_ptr_q      <= '0;
            remaining_q   <= '0;
            kind_q        <= 1'b0;
            first_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_is_dllp_q <= 1'b0;
        end else begin
            wstate_q      <= wstate_d;
            wr_tmp_q      <= wr_tmp_d;
            wr_commit_q   <= wr_commit_d;
            len_q         <= len_d;
            push_q        <= push_d;
            push_data_q   <= push_data_d;
            drop_q        <= drop_d;
            null_q        <= null_d;
            rstate_q      <= rstate_d;
            rd_ptr_q      <= rd_ptr_d;
            remaining_q   <= remaining_d;
            kind_q        <= kind_d;
            first_q       <= first_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_is_dllp_q <= out_is_dllp_d;
        end
    end

    // Payload RAM write port.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_tmp_q[AW-1:0]] <= in_data;
    end

    gen3_desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .WIDTH ($bits(desc_t))
    ) u_desc_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (pop),
        .rd_data_c (desc_rd),
        .full_c    (desc_full_c),
        .empty_c   (desc_empty_c)
    );

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_sop       = out_sop_q;
    assign out_eop       = out_eop_q;
    assign out_is_dllp   = out_is_dllp_q;
    assign nullify_count = null_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_gen3_packet_assembler.sv
// Directed self-checking bench for gen3_packet_assembler.
module tb_gen3_packet_assembler;

    localparam logic [5:0] C_DATA  = 6'b100000;
    localparam logic [5:0] C_TSTRT = 6'b010000;
    localparam logic [5:0] C_TEND  = 6'b001000;
    localparam logic [5:0] C_DEND  = 6'b000100;
    localparam logic [5:0] C_DSTRT = 6'b000010;
    localparam logic [5:0] C_EDB   = 6'b000001;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [5:0] in_type;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_is_dllp;
    logic [7:0] nullify_count;
    logic [7:0] drop_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Accepted bytes as {is_dllp, sop, eop, data}.
    logic [10:0] obs_q[$];
    int          eop_seen = 0;

    always #5 clk = ~clk;

    gen3_packet_assembler dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_type       (in_type),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_sop       (out_sop),
        .out_eop       (out_eop),
        .out_is_dllp   (out_is_dllp),
        .nullify_count (nullify_count),
        .drop_count    (drop_count)
    );

    // Record each byte that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            obs_q.push_back({out_is_dllp, out_sop, out_eop, out_data});
            if (out_eop) eop_seen++;
        end
    end

    task automatic send(input logic [5:0] t, input logic [7:0] d);
        in_valid = 1'b1;
        in_type  = t;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_type  = 6'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int c = 0;
        while (obs_q.size() < n && c < budget) begin
            @(posedge clk);
            #2;
            c++;
        end
        total_cnt++;
        if (obs_q.size() < n) $display("FAIL %s_timeout: got %0d bytes expected %0d", name, obs_q.size(), n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_type = 6'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", out_data); else pass_cnt++;
        total_cnt++; if ({out_sop, out_eop, out_is_dllp} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {out_sop, out_eop, out_is_dllp}); else pass_cnt++;
        total_cnt++; if (nullify_count !== 8'd0) $display("FAIL reset_nullify: got %0d expected 0", nullify_count); else pass_cnt++;
        total_cnt++; if (drop_count !== 8'd0) $display("FAIL reset_drop: got %0d expected 0", drop_count); else pass_cnt++;
    endtask

    task automatic test_dllp();
        logic [10:0] exp;
        obs_q.delete();
        out_ready = 1'b1;
        send(C_DSTRT, 8'h00);
        for (int i = 0; i < 4; i++) send(C_DATA, 8'hA1 + 8'(i));
        send(C_DEND, 8'h00);
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL lat_n0: got %b expected 0", out_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL lat_n1: got %b expected 0", out_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL lat_n2: got %b expected 1", out_valid); else pass_cnt++;
        wait_bytes(4, 20, "dllp");
        repeat (6) @(posedge clk);
        #1;
        total_cnt++; if (obs_q.size() != 4) $display("FAIL dllp_count: got %0d expected 4", obs_q.size()); else pass_cnt++;
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            exp = {1'b1, (i == 0), (i == 3), 8'hA1 + 8'(i)};
            total_cnt++; if (obs_q[i] !== exp) $display("FAIL dllp_byte%0d: got %h expected %h", i, obs_q[i], exp); else pass_cnt++;
        end
        total_cnt++; if ({nullify_count, drop_count} !== 16'h0000) $display("FAIL dllp_counters: got %h expected 0000", {nullify_count, drop_count}); else pass_cnt++;
    endtask

    task automatic test_edb();
        obs_q.delete();
        send(C_TSTRT, 8'h00);
        for (int i = 0; i < 3; i++) send(C_DATA, 8'h70 + 8'(i));
        send(C_EDB, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        total_cnt++; if (obs_q.size() != 0) $display("FAIL edb_output: got %0d bytes expected 0", obs_q.size()); else pass_cnt++;
        total_cnt++; if (nullify_count !== 8'd1) $display("FAIL edb_nullify: got %0d expected 1", nullify_count); else pass_cnt++;
        total_cnt++; if (drop_count !== 8'd0) $display("FAIL edb_drop: got %0d expected 0", drop_count); else pass_cnt++;
    endtask

    task automatic test_overflow();
        obs_q.delete();
        send(C_TSTRT, 8'h00);
        for (int i = 0; i < 33; i++) send(C_DATA, 8'(i));
        send(C_TEND, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        total_cnt++; if (obs_q.size() != 0) $display("FAIL ovf_output: got %0d bytes expected 0", obs_q.size()); else pass_cnt++;
        total_cnt++; if (drop_count !== 8'd1) $display("FAIL ovf_drop: got %0d expected 1", drop_count); else pass_cnt++;
    endtask

    task automatic test_restart();
        obs_q.delete();
        send(C_TSTRT, 8'h00);
        send(C_DATA, 8'h41);
        send(C_DATA, 8'h42);
        send(C_DSTRT, 8'h00);
        send(C_DATA, 8'h51);
        send(C_DATA, 8'h52);
        send(C_DEND, 8'h00);
        wait_bytes(2, 20, "restart");
        repeat (8) @(posedge clk);
        #1;
        total_cnt++; if (obs_q.size() != 2) $display("FAIL restart_count: got %0d expected 2", obs_q.size()); else pass_cnt++;
        if (obs_q.size() >= 2) begin
            total_cnt++; if (obs_q[0] !== 11'h651) $display("FAIL restart_b0: got %h expected 651", obs_q[0]); else pass_cnt++;
            total_cnt++; if (obs_q[1] !== 11'h552) $display("FAIL restart_b1: got %h expected 552", obs_q[1]); else pass_cnt++;
        end
        total_cnt++; if (drop_count !== 8'd2) $display("FAIL restart_drop: got %0d expected 2", drop_count); else pass_cnt++;
    endtask

    task automatic test_desc_full();
        logic [12:0] snap;
        logic        stalled;
        logic [10:0] exp;
        obs_q.delete();
        out_ready = 1'b0;
        for (int p = 0; p < 5; p++) begin
            send(C_TSTRT, 8'h00);
            for (int j = 0; j < 4; j++) send(C_DATA, 8'h10 + 8'(p * 4 + j));
            send(C_TEND, 8'h00);
        end
        repeat (5) @(posedge clk);
        #1;
        total_cnt++; if (drop_count !== 8'd3) $display("FAIL full_drop: got %0d expected 3", drop_count); else pass_cnt++;
        total_cnt++; if ({out_valid, out_sop, out_is_dllp, out_data} !== 11'h610) $display("FAIL full_head: got %h expected 610", {out_valid, out_sop, out_is_dllp, out_data}); else pass_cnt++;
        snap = 13'h0;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 200 && obs_q.size() < 16; cyc++) begin
            @(posedge clk);
            #1;
            out_ready = ((cyc % 3) != 0);
            @(negedge clk);
            if (stalled) begin
                total_cnt++;
                if ({out_valid, out_sop, out_eop, out_is_dllp, out_data, 1'b0} !== snap)
                    $display("FAIL stall_hold%0d: got %h expected %h", cyc, {out_valid, out_sop, out_eop, out_is_dllp, out_data, 1'b0}, snap);
                else pass_cnt++;
            end
            snap = {out_valid, out_sop, out_eop, out_is_dllp, out_data, 1'b0};
            stalled = out_valid && !out_ready;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_bytes(16, 40, "full");
        repeat (10) @(posedge clk);
        #1;
        total_cnt++; if (obs_q.size() != 16) $display("FAIL full_count: got %0d expected 16", obs_q.size()); else pass_cnt++;
        for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
            exp = {1'b0, ((i % 4) == 0), ((i % 4) == 3), 8'h10 + 8'(i)};
            total_cnt++; if (obs_q[i] !== exp) $display("FAIL full_byte%0d: got %h expected %h", i, obs_q[i], exp); else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        logic [10:0] exp;
        bit          done = 1'b0;
        obs_q.delete();
        eop_seen = 0;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    for (int g = 0; g < 500 && (k - eop_seen) >= 3; g++) begin
                        @(posedge clk);
                        #1;
                    end
                    send(C_TSTRT, 8'h00);
                    for (int j = 0; j < 10; j++) send(C_DATA, 8'(k * 13 + j));
                    send(C_TEND, 8'h00);
                end
                done = 1'b1;
            end
            begin
                for (int g = 0; g < 6000 && !(done && eop_seen >= 20); g++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_bytes(200, 100, "wrap");
        total_cnt++; if (obs_q.size() != 200) $display("FAIL wrap_count: got %0d expected 200", obs_q.size()); else pass_cnt++;
        for (int i = 0; i < 200 && i < obs_q.size(); i++) begin
            exp = {1'b0, ((i % 10) == 0), ((i % 10) == 9), 8'((i / 10) * 13 + (i % 10))};
            total_cnt++; if (obs_q[i] !== exp) $display("FAIL wrap_byte%0d: got %h expected %h", i, obs_q[i], exp); else pass_cnt++;
        end
        total_cnt++; if ({nullify_count, drop_count} !== 16'h0103) $display("FAIL wrap_counters: got %h expected 0103", {nullify_count, drop_count}); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(C_TSTRT, 8'h00);
        for (int j = 0; j < 3; j++) send(C_DATA, 8'hC0 + 8'(j));
        send(C_TEND, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b expected 1", out_valid); else pass_cnt++;
        send(C_TSTRT, 8'h00);
        send(C_DATA, 8'hD0);
        send(C_DATA, 8'hD1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (drop_count !== 8'd0) $display("FAIL rstmid_drop: got %0d expected 0", drop_count); else pass_cnt++;
        total_cnt++; if (nullify_count !== 8'd0) $display("FAIL rstmid_nullify: got %0d expected 0", nullify_count); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_post_valid: got %b expected 0", out_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_dllp();
        test_edb();
        test_overflow();
        test_restart();
        test_desc_full();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
